// File: rtl/wb_uart_port.sv
// Wishbone responder bridging CPU loads/stores to tty byte streams through
// one small FIFO per direction, with polled DATA and STATUS registers.
module wb_uart_port #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int SELECT_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic                    we_i,
  input  logic [SELECT_WIDTH-1:0] sel_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  output logic                    ack_o,
  output logic [7:0]              uart_tx_data,
  output logic                    uart_tx_valid,
  input  logic                    uart_tx_ready,
  input  logic [7:0]              uart_rx_data,
  input  logic                    uart_rx_valid,
  output logic                    uart_rx_ready
);

  localparam int PTR_W = FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PAD_W = 8 - CNT_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1) << FIFO_DEPTH_LOG2;

  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             tx_ovf;

  logic                  accept, data_wr, tx_full, rx_nonempty;
  logic                  tx_push, tx_pop, rx_push, rx_pop, ovf_clr;
  logic [1:0]            reg_sel;
  logic [DATA_WIDTH-1:0] status_word, read_data;
  logic                  unused_ok;

  // Both byte streams use valid/ready: a byte moves on a clk edge where
  // valid & ready are both high; the source holds data stable until then.
  assign uart_tx_valid = (tx_count != '0);
  assign uart_tx_data  = tx_mem[tx_rd_ptr];
  assign uart_rx_ready = ~rst & (rx_count != FULL_COUNT);

  assign accept      = cyc_i & stb_i & ~ack_o;
  assign reg_sel     = adr_i[3:2];
  assign data_wr     = accept & we_i & (reg_sel == 2'd0) & sel_i[0];
  assign tx_full     = (tx_count == FULL_COUNT);
  assign rx_nonempty = (rx_count != '0);
  assign tx_push     = data_wr & ~tx_full;
  assign tx_pop      = uart_tx_valid & uart_tx_ready;
  assign rx_push     = uart_rx_valid & uart_rx_ready;
  assign rx_pop      = accept & ~we_i & (reg_sel == 2'd0) & rx_nonempty;
  assign ovf_clr     = accept & we_i & (reg_sel == 2'd1) & sel_i[0] & dat_i[2];

  assign status_word = {8'h00, {PAD_W{1'b0}}, tx_count, {PAD_W{1'b0}}, rx_count,
                        5'b0, tx_ovf, ~tx_full, rx_nonempty};
  assign unused_ok   = ^{dat_i[DATA_WIDTH-1:8], sel_i[SELECT_WIDTH-1:1], adr_i[1:0]};

  always_comb begin
    read_data = '0;
    case (reg_sel)
      2'd0:    if (rx_nonempty) read_data = {23'b0, 1'b1, rx_mem[rx_rd_ptr]};
      2'd1:    read_data = status_word;
      default: read_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= dat_i[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      tx_ovf    <= 1'b0;
      ack_o     <= 1'b0;
      dat_o     <= '0;
    end else begin
      ack_o <= accept;
      dat_o <= (accept & ~we_i) ? read_data : '0;

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase

      // A write into a full TX FIFO is lost even if the tty drains this cycle.
      if (data_wr & tx_full) tx_ovf <= 1'b1;
      else if (ovf_clr)      tx_ovf <= 1'b0;
    end
  end

endmodule
